fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_buffer.sv | 81 ++++++++
 rtl/fetch_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_unit_pkg;

   localparam logic [31:0] NopInstr           = 32'h0000_0013;
   localparam logic [31:0] DefaultResetVector = 32'h0000_0000;
   localparam int unsigned FifoDepth          = 2;
   localparam int unsigned FifoCntW           = $clog2(FifoDepth + 1);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus between the fetch unit and memory.
interface fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc, instruction} entries holding responses while decode is stalled.
module fetch_buffer
   import fetch_unit_pkg::*;
#(
   parameter int unsigned Depth = FifoDepth
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  fetch_entry_t               wdata,
   input  logic                       pop,
   output fetch_entry_t               rdata,
   input  logic                       clear,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(Depth+1)-1:0] count
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   fetch_entry_t    mem_q [Depth];
   fetch_entry_t    mem_d [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            do_push, do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
      return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign full    = (count_q == CntW'(Depth));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
         end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches, buffers in-order responses and
// presents one registered instruction per cycle to decode, with redirect flush.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DefaultResetVector
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         stall,
   input  logic         redirect,
   input  logic [31:0]  redirect_pc,
   fetch_unit_if.master imem,
   output logic [31:0]  instruction,
   output logic [31:0]  pc,
   output logic         inst_valid
);

   logic [31:0]         fetch_pc_q, fetch_pc_d;
   logic [31:0]         resp_pc_q, resp_pc_d;
   logic [31:0]         instr_q, instr_d;
   logic [31:0]         pc_q, pc_d;
   logic                valid_q, valid_d;
   logic [1:0]          outstanding_q, outstanding_d;
   logic [1:0]          discard_q, discard_d;

   logic                buf_push, buf_pop, buf_clear;
   logic                buf_full, buf_empty;
   logic [FifoCntW-1:0] buf_count;
   fetch_entry_t        buf_wdata, buf_rdata;

   logic [2:0]          in_flight;
   logic                req, grant, live, drop;

   fetch_buffer #(
      .Depth (FifoDepth)
   ) u_buffer (
      .clk   (clk),
      .rst   (rst),
      .push  (buf_push),
      .wdata (buf_wdata),
      .pop   (buf_pop),
      .rdata (buf_rdata),
      .clear (buf_clear),
      .full  (buf_full),
      .empty (buf_empty),
      .count (buf_count)
   );

   // Discarded requests still occupy a response slot, so they count toward the limit.
   assign in_flight = 3'(outstanding_q) + 3'(discard_q) + 3'(buf_count);
   assign req       = !rst && !buf_full && (in_flight < 3'(FifoDepth));
   assign grant     = req && imem.imem_gnt;
   assign drop      = imem.imem_rvalid && (discard_q != 2'd0);
   assign live      = imem.imem_rvalid && (discard_q == 2'd0);

   assign imem.imem_req  = req;
   assign imem.imem_addr = fetch_pc_q;

   always_comb begin
      fetch_pc_d      = fetch_pc_q;
      resp_pc_d       = resp_pc_q;
      outstanding_d   = outstanding_q;
      discard_d       = discard_q;
      instr_d         = instr_q;
      pc_d            = pc_q;
      valid_d         = valid_q;
      buf_push        = 1'b0;
      buf_pop         = 1'b0;
      buf_clear       = 1'b0;
      buf_wdata.pc    = resp_pc_q;
      buf_wdata.instr = imem.imem_rdata;

      if (redirect) begin
         fetch_pc_d    = word_align(redirect_pc);
         resp_pc_d     = word_align(redirect_pc);
         outstanding_d = 2'd0;
         discard_d     = 2'(3'(discard_q) + 3'(outstanding_q) + 3'(grant)
                            - 3'(imem.imem_rvalid));
         buf_clear     = 1'b1;
         instr_d       = NopInstr;
         valid_d       = 1'b0;
      end else begin
         if (grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (drop) begin
            discard_d = discard_q - 2'd1;
         end
         outstanding_d = outstanding_q + 2'(grant) - 2'(live);
         // Live responses come back in order from a contiguous run of fetch PCs,
         // so a running counter reproduces the PC each request was granted with.
         if (live) begin
            resp_pc_d = resp_pc_q + 32'd4;
         end
         if (stall) begin
            buf_push = live;
         end else if (!buf_empty) begin
            buf_pop  = 1'b1;
            buf_push = live;
            instr_d  = buf_rdata.instr;
            pc_d     = buf_rdata.pc;
            valid_d  = 1'b1;
         end else if (live) begin
            instr_d = imem.imem_rdata;
            pc_d    = resp_pc_q;
            valid_d = 1'b1;
         end else begin
            instr_d = NopInstr;
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_VECTOR;
         resp_pc_q     <= RESET_VECTOR;
         outstanding_q <= 2'd0;
         discard_q     <= 2'd0;
         instr_q       <= NopInstr;
         pc_q          <= RESET_VECTOR;
         valid_q       <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         instr_q       <= instr_d;
         pc_q          <= pc_d;
         valid_q       <= valid_d;
      end
   end

   assign instruction = instr_q;
   assign pc          = pc_q;
   assign inst_valid  = valid_q;

endmodule
